// File: rtl/xc_aes_pkg.sv
// Shared AES constants and GF(2^8) helpers for the crypto instruction units.
// The MixColumns unit reuses AesPoly for its xtime reduction.
package xc_aes_pkg;

    localparam logic [7:0] AesPoly     = 8'h1b;
    localparam logic [7:0] AffFwdConst = 8'h63;
    localparam logic [7:0] AffInvConst = 8'h05;

    // Rotation offsets of the forward and inverse affine transforms.
    localparam int unsigned AffFwdRot0 = 1;
    localparam int unsigned AffFwdRot1 = 2;
    localparam int unsigned AffFwdRot2 = 3;
    localparam int unsigned AffFwdRot3 = 4;
    localparam int unsigned AffInvRot0 = 1;
    localparam int unsigned AffInvRot1 = 3;
    localparam int unsigned AffInvRot2 = 6;

    // Byte-serial S-box state: which operand byte feeds the shared S-box.
    typedef enum logic [1:0] {
        StC0,
        StC1,
        StC2,
        StC3
    } aessub_fsm_e;

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AesPoly : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

    // a^254 by square-and-multiply; maps 0 to 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ rotl8(x, AffFwdRot0) ^ rotl8(x, AffFwdRot1) ^ rotl8(x, AffFwdRot2)
                 ^ rotl8(x, AffFwdRot3) ^ AffFwdConst;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] s);
        return rotl8(s, AffInvRot0) ^ rotl8(s, AffInvRot1) ^ rotl8(s, AffInvRot2) ^ AffInvConst;
    endfunction

endpackage

// File: rtl/xc_aessub_sbox.sv
// Single-byte combinational AES S-box / inverse S-box built from affine maps
// around a GF(2^8) inversion, so no lookup table is needed.
module xc_aessub_sbox (
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);
    import xc_aes_pkg::*;

    logic [7:0] gf_in;
    logic [7:0] gf_out;

    always_comb begin
        gf_in  = inv ? aff_inv(in) : in;
        gf_out = gf_inv(gf_in);
        out    = inv ? gf_out : aff_fwd(gf_out);
    end

endmodule

// File: rtl/xc_aessub.sv
// AES SubBytes / InvSubBytes instruction unit feeding MixColumns.
// FAST=1: four S-boxes, single cycle. FAST=0: one shared S-box, byte-serial over 4 cycles.
module xc_aessub #(
    parameter bit FAST = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic        enc,
    output logic        ready,
    output logic [31:0] result
);
    import xc_aes_pkg::*;

    logic [7:0] byte_in [4];
    logic       unused_ops;

    // Gate operands with valid so idle cycles do not toggle the S-box logic.
    assign byte_in[0] = rs1[7:0]   & {8{valid}};
    assign byte_in[1] = rs1[15:8]  & {8{valid}};
    assign byte_in[2] = rs2[23:16] & {8{valid}};
    assign byte_in[3] = rs2[31:24] & {8{valid}};

    assign unused_ops = ^{rs1[31:16], rs2[15:0]};

    if (FAST) begin : g_fast
        logic [7:0] sbox_out [4];
        logic       unused_seq;

        for (genvar i = 0; i < 4; i++) begin : g_sbox
            xc_aessub_sbox u_sbox (
                .in  (byte_in[i]),
                .inv (~enc),
                .out (sbox_out[i])
            );
        end

        assign unused_seq = ^{clock, reset, flush};
        assign ready      = valid;
        assign result     = {sbox_out[3], sbox_out[2], sbox_out[1], sbox_out[0]} & {32{valid}};
    end else begin : g_serial
        aessub_fsm_e fsm_q, fsm_d;
        logic [7:0]  r0_q, r0_d;
        logic [7:0]  r1_q, r1_d;
        logic [7:0]  r2_q, r2_d;
        logic [7:0]  sbox_in;
        logic [7:0]  sbox_out;

        assign sbox_in = byte_in[fsm_q];

        xc_aessub_sbox u_sbox (
            .in  (sbox_in),
            .inv (~enc),
            .out (sbox_out)
        );

        // The last byte comes straight from the S-box, so ready lands in C3.
        assign ready  = (fsm_q == StC3) && valid;
        assign result = {sbox_out, r2_q, r1_q, r0_q} & {32{ready}};

        always_comb begin
            fsm_d = fsm_q;
            r0_d  = r0_q;
            r1_d  = r1_q;
            r2_d  = r2_q;

            if (flush) begin
                fsm_d = StC0;
            end else if (valid && !ready) begin
                case (fsm_q)
                    StC0:    fsm_d = StC1;
                    StC1:    fsm_d = StC2;
                    StC2:    fsm_d = StC3;
                    default: fsm_d = StC3;
                endcase
            end

            if (valid) begin
                case (fsm_q)
                    StC0:    r0_d = sbox_out;
                    StC1:    r1_d = sbox_out;
                    StC2:    r2_d = sbox_out;
                    default: ;
                endcase
            end
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                fsm_q <= StC0;
                r0_q  <= 8'h00;
                r1_q  <= 8'h00;
                r2_q  <= 8'h00;
            end else begin
                fsm_q <= fsm_d;
                r0_q  <= r0_d;
                r1_q  <= r1_d;
                r2_q  <= r2_d;
            end
        end
    end

endmodule

// File: tb/tb_xc_aessub.sv
// Bench for xc_aessub: one FAST=1 and one FAST=0 instance checked against the
// AES S-box table through an expected-result queue.
module tb_xc_aessub;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        f_flush = 1'b0;
    logic        f_valid, f_enc, f_ready;
    logic [31:0] f_rs1, f_rs2, f_result;
    logic        s_flush, s_valid, s_enc, s_ready;
    logic [31:0] s_rs1, s_rs2, s_result;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] exp_q [$];

    logic [7:0] sbox_tbl [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    xc_aessub #(.FAST(1'b1)) u_dut_fast (
        .clock  (clock),
        .reset  (reset),
        .flush  (f_flush),
        .valid  (f_valid),
        .rs1    (f_rs1),
        .rs2    (f_rs2),
        .enc    (f_enc),
        .ready  (f_ready),
        .result (f_result)
    );

    xc_aessub #(.FAST(1'b0)) u_dut_slow (
        .clock  (clock),
        .reset  (reset),
        .flush  (s_flush),
        .valid  (s_valid),
        .rs1    (s_rs1),
        .rs2    (s_rs2),
        .enc    (s_enc),
        .ready  (s_ready),
        .result (s_result)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic fast_op(input logic [31:0] a, input logic [31:0] b, input logic e,
                           input logic [31:0] expv, input string tag);
        @(posedge clock); #1;
        f_rs1   = a;
        f_rs2   = b;
        f_enc   = e;
        f_valid = 1'b1;
        exp_q.push_back(expv);
        @(negedge clock);
        check_eq({tag, "_rdy"}, 32'(f_ready), 32'd1);
        check_eq(tag, f_result, exp_q.pop_front());
    endtask

    // Runs one serial instruction; valid is dropped for pause_len cycles once
    // pause_at valid cycles have elapsed. Ends with a flush back to C0.
    task automatic slow_run(input logic [31:0] a, input logic [31:0] b, input logic e,
                            input logic [31:0] expv, input string tag,
                            input int pause_at, input int pause_len);
        int vcyc;
        int npause;
        int guard;
        bit done;
        vcyc   = 0;
        npause = 0;
        guard  = 0;
        done   = 1'b0;
        @(posedge clock); #1;
        s_rs1 = a;
        s_rs2 = b;
        s_enc = e;
        exp_q.push_back(expv);
        while (!done && guard < 16) begin
            s_valid = !(vcyc == pause_at && npause < pause_len);
            @(negedge clock);
            if (!s_valid) begin
                check_eq({tag, "_pause"}, s_result | 32'(s_ready), 32'd0);
                npause++;
            end else if (s_ready) begin
                check_eq({tag, "_lat"}, 32'(vcyc), 32'd3);
                check_eq(tag, s_result, exp_q.pop_front());
                done = 1'b1;
            end else begin
                check_eq({tag, "_busy"}, s_result, 32'd0);
                vcyc++;
            end
            guard++;
            @(posedge clock); #1;
        end
        if (!done) begin
            check_eq({tag, "_timeout"}, 32'(done), 32'd1);
            void'(exp_q.pop_front());
        end
        s_valid = 1'b1;
        @(negedge clock);
        check_eq({tag, "_hold"}, 32'(s_ready), 32'd1);
        @(posedge clock); #1;
        s_flush = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        check_eq({tag, "_flush_rdy"}, 32'(s_ready), 32'd0);
        check_eq({tag, "_flush_res"}, s_result, 32'd0);
        @(posedge clock); #1;
        s_flush = 1'b0;
        s_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        f_valid = 1'b0;
        f_enc   = 1'b1;
        f_rs1   = 32'h0;
        f_rs2   = 32'h0;
        s_flush = 1'b0;
        s_valid = 1'b0;
        s_enc   = 1'b1;
        s_rs1   = 32'h0;
        s_rs2   = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_eq("rst_f_rdy", 32'(f_ready), 32'd0);
        check_eq("rst_f_res", f_result, 32'd0);
        check_eq("rst_s_rdy", 32'(s_ready), 32'd0);
        check_eq("rst_s_res", s_result, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        fast_op(32'h0000_0100, 32'hff53_0000, 1'b1, 32'h16ed7c63, "f_vec1");
        fast_op(32'h0000_7c63, 32'h16ed_0000, 1'b0, 32'hff530100, "f_vec2");
        @(posedge clock); #1;
        f_valid = 1'b0;
        @(negedge clock);
        check_eq("f_idle_rdy", 32'(f_ready), 32'd0);
        check_eq("f_idle_res", f_result, 32'd0);
        fast_op(32'h0000_0010, 32'h0, 1'b1, 32'h636363ca, "f_s10");
        fast_op(32'h0000_0020, 32'h0, 1'b1, 32'h636363b7, "f_s20");

        slow_run(32'h0000_0100, 32'hff53_0000, 1'b1, 32'h16ed7c63, "s_vec1", -1, 0);
        slow_run(32'h0000_0100, 32'hff53_0000, 1'b1, 32'h16ed7c63, "s_pause", 2, 2);

        // Reset while the shared S-box is working on byte 2.
        @(posedge clock); #1;
        s_rs1   = 32'h0000_0100;
        s_rs2   = 32'hff53_0000;
        s_enc   = 1'b1;
        s_valid = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check_eq("s_rst_rdy", 32'(s_ready), 32'd0);
        check_eq("s_rst_res", s_result, 32'd0);
        @(posedge clock); #1;
        s_valid = 1'b0;
        s_flush = 1'b1;
        @(posedge clock); #1;
        s_flush = 1'b0;
        slow_run(32'h0000_7c63, 32'h16ed_0000, 1'b0, 32'hff530100, "s_vec2", -1, 0);

        for (int x = 0; x < 256; x++) begin
            fast_op({24'h0, 8'(x)}, 32'h0, 1'b1, {24'h636363, sbox_tbl[x]},
                    $sformatf("f_fwd_%02h", x));
            fast_op({24'h0, sbox_tbl[x]}, 32'h0, 1'b0, {24'h525252, 8'(x)},
                    $sformatf("f_inv_%02h", x));
        end
        @(posedge clock); #1;
        f_valid = 1'b0;

        for (int x = 0; x < 256; x++) begin
            slow_run({24'h0, 8'(x)}, 32'h0, 1'b1, {24'h636363, sbox_tbl[x]},
                     $sformatf("s_fwd_%02h", x), -1, 0);
            slow_run({24'h0, sbox_tbl[x]}, 32'h0, 1'b0, {24'h525252, 8'(x)},
                     $sformatf("s_inv_%02h", x), -1, 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
